// File: rtl/key_pulse_gen.sv
// -----------------------------------------------------------------------------
// key_pulse_gen
//
// Conditions active-low pushbuttons: a 2-flop synchronizer, then a per-key
// debounce FSM with its own counter. The block produces a debounced level
// plus single-cycle press and release pulses.
//
// Ports
//   i_clk        system clock; all logic runs on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_key_n      raw pushbuttons, active-low, asynchronous, bouncy
//   o_level      debounced level per key (1 = pressed)
//   o_press      one-cycle pulse per key when a press is accepted
//   o_release    one-cycle pulse per key when a release is accepted
//   o_any_press  OR of the o_press bits, registered in the same cycle
//
// Handshake: there is none. Every output is a plain level or pulse, sampled
// by the consumer on any rising edge of i_clk.
//
// Timing: if the raw key is first sampled low at edge k and then held low,
// the FSM enters S_DN_CHK at edge k+2. o_press and o_level rise at edge
// k+DEB_CYCLES+2, and o_press falls at k+DEB_CYCLES+3. Release is symmetric.
// -----------------------------------------------------------------------------
module key_pulse_gen #(
  parameter int N_KEYS     = 4,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key_n,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic              o_any_press
);

  // The counter only has to reach DEB_CYCLES-1, so $clog2 bits are enough.
  // The guard keeps the width at one bit or more for small parameter values.
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_UP     = 2'd0,
    S_DN_CHK = 2'd1,
    S_DN     = 2'd2,
    S_UP_CHK = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizer. Both stages reset to 1 so that after reset every key reads
  // as released. A key that is still held then looks like a new press.
  // ---------------------------------------------------------------------------
  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= i_key_n;
      sync2_q <= sync1_q;
    end
  end

  // Per-key next-cycle pulse requests, gathered for the shared output register.
  logic [N_KEYS-1:0] press_d;
  logic [N_KEYS-1:0] release_d;

  // ---------------------------------------------------------------------------
  // Per-key debounce FSM: a state register, next-state logic and output decode.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pressed;
    logic          key_press_d;
    logic          key_release_d;
    logic          key_level;

    assign pressed = ~sync2_q[g];

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q <= S_UP;
        cnt_q   <= CNT_ZERO;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Next-state logic. The counter is cleared on every entry into a CHK
    // state. A bounce back to the stable side drops the candidate without
    // a pulse, so the next qualifying edge starts counting again from zero.
    always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      key_press_d   = 1'b0;
      key_release_d = 1'b0;
      case (state_q)
        S_UP: begin
          cnt_d = CNT_ZERO;
          if (pressed) begin
            state_d = S_DN_CHK;
          end
        end
        S_DN_CHK: begin
          if (!pressed) begin
            state_d = S_UP;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_MAX) begin
            state_d     = S_DN;
            cnt_d       = CNT_ZERO;
            key_press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_DN: begin
          cnt_d = CNT_ZERO;
          if (!pressed) begin
            state_d = S_UP_CHK;
          end
        end
        S_UP_CHK: begin
          if (pressed) begin
            state_d = S_DN;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == CNT_MAX) begin
            state_d       = S_UP;
            cnt_d         = CNT_ZERO;
            key_release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = S_UP;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    // Output decode. The debounced level follows the accepted state, so it
    // changes on the same edge that registers the press or release pulse.
    always_comb begin
      key_level = 1'b0;
      case (state_q)
        S_DN, S_UP_CHK: key_level = 1'b1;
        default:        key_level = 1'b0;
      endcase
    end

    assign press_d[g]   = key_press_d;
    assign release_d[g] = key_release_d;
    assign o_level[g]   = key_level;
  end

  // ---------------------------------------------------------------------------
  // Registered pulses. o_any_press is computed from the same next-cycle
  // request vector, so it lines up exactly with o_press.
  // ---------------------------------------------------------------------------
  logic [N_KEYS-1:0] press_q;
  logic [N_KEYS-1:0] release_q;
  logic              any_press_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
    end else begin
      press_q     <= press_d;
      release_q   <= release_d;
      any_press_q <= |press_d;
    end
  end

  assign o_press     = press_q;
  assign o_release   = release_q;
  assign o_any_press = any_press_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_key_pulse_gen
//
// Bench for key_pulse_gen with N_KEYS = 2 and DEB_CYCLES = 4. Each scenario
// task drives the keys and pushes the pulses it expects (edge number plus the
// press, release and any_press values) into exp_q. A negedge monitor pops an
// entry whenever the DUT shows a pulse. The scenario tasks also check levels
// inline.
// -----------------------------------------------------------------------------
module tb_key_pulse_gen;

  localparam int N_KEYS = 2;
  localparam int DEB    = 4;
  localparam int LAT    = DEB + 2;   // first low sample to o_press / o_level
  localparam int W      = 32 + 2 + 2 + 1;

  // ---------------------------------------------------------------- clock/reset
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N_KEYS-1:0] key_n = '1;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] release_p;
  logic              any_press;

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no = edge_no + 1;

  key_pulse_gen #(
    .N_KEYS    (N_KEYS),
    .DEB_CYCLES(DEB)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_key_n    (key_n),
    .o_level    (level),
    .o_press    (press),
    .o_release  (release_p),
    .o_any_press(any_press)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Every pulse the DUT shows must match the oldest expected entry, including
  // the edge number on which it appeared.
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (rst_n && ((press != '0) || (release_p != '0) || any_press)) begin
      got = {edge_no[31:0], press, release_p, any_press};
      n_vec = n_vec + 1;
      if (exp_q.size() == 0) begin
        n_err = n_err + 1;
        $display("FAIL unexpected_pulse edge=%0d press=%b release=%b any=%b",
                 edge_no, press, release_p, any_press);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_err = n_err + 1;
          $display("FAIL pulse got edge=%0d p=%b r=%b a=%b, need edge=%0d p=%b r=%b a=%b",
                   got[W-1:5], got[4:3], got[2:1], got[0],
                   exp[W-1:5], exp[4:3], exp[2:1], exp[0]);
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int e);
    while (edge_no < e) @(negedge clk);
  endtask

  task automatic push_exp(input int e, input logic [1:0] p, input logic [1:0] r);
    exp_q.push_back({e[31:0], p, r, |p});
  endtask

  // Confirms that every expected pulse was seen, then clears the queue.
  task automatic drain(input string name);
    n_vec = n_vec + 1;
    if (exp_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL %s missing_pulses outstanding=%0d need=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    key_n = '1;
    wait_edges(3);
    n_vec = n_vec + 1;
    if ({level, press, release_p, any_press} !== 7'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset_outputs got=%b need=0", {level, press, release_p, any_press});
    end
    rst_n = 1'b1;
    wait_edges(4);
    n_vec = n_vec + 1;
    if (level !== 2'b00) begin
      n_err = n_err + 1;
      $display("FAIL idle_level got=%b need=00", level);
    end
  endtask

  // Clean press held for a long time (single pulse only), then a clean release.
  task automatic test_clean_press_release();
    int k;
    @(negedge clk);
    key_n[0] = 1'b0;
    k = edge_no + 1;
    push_exp(k + LAT, 2'b01, 2'b00);
    wait_until(k + LAT - 1);
    n_vec = n_vec + 1;
    if (level !== 2'b00) begin
      n_err = n_err + 1;
      $display("FAIL press_level_early got=%b need=00", level);
    end
    wait_until(k + LAT);
    n_vec = n_vec + 1;
    if (level !== 2'b01) begin
      n_err = n_err + 1;
      $display("FAIL press_level_rise got=%b need=01", level);
    end
    wait_edges(20 + $urandom_range(0, 5));
    n_vec = n_vec + 1;
    if (level !== 2'b01) begin
      n_err = n_err + 1;
      $display("FAIL held_level got=%b need=01", level);
    end
    key_n[0] = 1'b1;
    k = edge_no + 1;
    push_exp(k + LAT, 2'b00, 2'b01);
    wait_until(k + LAT - 1);
    n_vec = n_vec + 1;
    if (level !== 2'b01) begin
      n_err = n_err + 1;
      $display("FAIL release_level_early got=%b need=01", level);
    end
    wait_until(k + LAT);
    n_vec = n_vec + 1;
    if (level !== 2'b00) begin
      n_err = n_err + 1;
      $display("FAIL release_level_fall got=%b need=00", level);
    end
    wait_edges(8);
    drain("clean_press_release");
  endtask

  // Low excursions of 1..DEB-1 raw cycles are all rejected.
  task automatic test_glitch();
    for (int len = 1; len < DEB; len++) begin
      @(negedge clk);
      key_n[0] = 1'b0;
      wait_edges(len);
      key_n[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        n_vec = n_vec + 1;
        if (level !== 2'b00) begin
          n_err = n_err + 1;
          $display("FAIL glitch_level len=%0d got=%b need=00", len, level);
        end
      end
    end
    drain("glitch");
  endtask

  // Press with bounce: low 2, high 1, low 2, high 1, then stable low.
  // A single pulse LAT edges after the stable low starts. A bouncy release
  // follows, giving a single release pulse.
  task automatic test_bounce();
    int k;
    logic pat [6];
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      key_n[0] = pat[i];
    end
    @(negedge clk);
    key_n[0] = 1'b0;
    k = edge_no + 1;
    push_exp(k + LAT, 2'b01, 2'b00);
    wait_until(k + LAT + 6);
    n_vec = n_vec + 1;
    if (level !== 2'b01) begin
      n_err = n_err + 1;
      $display("FAIL bounce_level got=%b need=01", level);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      key_n[0] = ~pat[i];
    end
    @(negedge clk);
    key_n[0] = 1'b1;
    k = edge_no + 1;
    push_exp(k + LAT, 2'b00, 2'b01);
    wait_until(k + LAT);
    n_vec = n_vec + 1;
    if (level !== 2'b00) begin
      n_err = n_err + 1;
      $display("FAIL bounce_release_level got=%b need=00", level);
    end
    wait_edges(6);
    drain("bounce");
  endtask

  // Both keys pressed on the same edge: press=11 and any_press in one cycle.
  task automatic test_simultaneous();
    int k;
    @(negedge clk);
    key_n = 2'b00;
    k = edge_no + 1;
    push_exp(k + LAT, 2'b11, 2'b00);
    wait_until(k + LAT);
    n_vec = n_vec + 1;
    if (level !== 2'b11) begin
      n_err = n_err + 1;
      $display("FAIL simul_level got=%b need=11", level);
    end
    wait_edges(4);
    key_n = 2'b11;
    k = edge_no + 1;
    push_exp(k + LAT, 2'b00, 2'b11);
    wait_until(k + LAT + 4);
    n_vec = n_vec + 1;
    if (level !== 2'b00) begin
      n_err = n_err + 1;
      $display("FAIL simul_release_level got=%b need=00", level);
    end
    drain("simultaneous");
  endtask

  // Keys pressed a few cycles apart. Each key pulses on its own schedule.
  task automatic test_staggered();
    int k0;
    int k1;
    int gap;
    gap = $urandom_range(1, 3);
    @(negedge clk);
    key_n[1] = 1'b0;
    k1 = edge_no + 1;
    push_exp(k1 + LAT, 2'b10, 2'b00);
    wait_edges(gap);
    key_n[0] = 1'b0;
    k0 = edge_no + 1;
    push_exp(k0 + LAT, 2'b01, 2'b00);
    wait_until(k0 + LAT + 3);
    key_n = 2'b11;
    k0 = edge_no + 1;
    push_exp(k0 + LAT, 2'b00, 2'b11);
    wait_until(k0 + LAT + 3);
    drain("staggered");
  endtask

  // Reset asserted mid-count with the key held. The outputs clear at once.
  // After release of reset the held key is treated as a new press.
  task automatic test_reset_mid();
    int k;
    @(negedge clk);
    key_n[0] = 1'b0;
    wait_edges(4);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec = n_vec + 1;
    if ({level, press, release_p, any_press} !== 7'b0) begin
      n_err = n_err + 1;
      $display("FAIL async_reset_outputs got=%b need=0", {level, press, release_p, any_press});
    end
    wait_edges(3);
    n_vec = n_vec + 1;
    if ({level, press, release_p, any_press} !== 7'b0) begin
      n_err = n_err + 1;
      $display("FAIL reset_hold_outputs got=%b need=0", {level, press, release_p, any_press});
    end
    rst_n = 1'b1;
    k = edge_no + 1;
    push_exp(k + LAT, 2'b01, 2'b00);
    wait_until(k + LAT - 1);
    n_vec = n_vec + 1;
    if (level !== 2'b00) begin
      n_err = n_err + 1;
      $display("FAIL post_reset_early got=%b need=00", level);
    end
    wait_until(k + LAT + 2);
    key_n[0] = 1'b1;
    k = edge_no + 1;
    push_exp(k + LAT, 2'b00, 2'b01);
    wait_until(k + LAT + 3);
    drain("reset_mid");
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_clean_press_release();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_staggered();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
